// File: rtl/backbone_pkg.sv
// Shared types and default geometry for the conv1 backbone scheduler.
// Provides the scheduler state enum, tile counts and the tile_eff() helper.
package backbone_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LWAIT,
    S_COMP,
    S_CWAIT,
    S_ADV,
    S_FIN
  } sched_state_t;

  localparam int DEF_COLS    = 16;
  localparam int DEF_K_TILE  = 16;
  localparam int DEF_K_TOTAL = 147;
  localparam int DEF_N_TOTAL = 64;

  localparam int NUM_KT =
    (DEF_K_TOTAL + DEF_K_TILE - 1) / DEF_K_TILE;
  localparam int NUM_NT =
    (DEF_N_TOTAL + DEF_COLS - 1) / DEF_COLS;

  // Width of the tile starting at base, clipped at total.
  function automatic int tile_eff(
    input int base,
    input int tile,
    input int total
  );
    int rem;
    rem = (base >= total) ? 0 : total - base;
    return (rem < tile) ? rem : tile;
  endfunction

endpackage

// File: rtl/conv1_tile_scheduler.sv
// conv1 GEMM tile sequencer: per tile, pulse loader, wait; pulse array, wait.
// Ports: clk, rst_n (sync, low), start/busy/done, ld_start/ld_done,
//   cmp_start/cmp_done, tile_k_base, tile_n_base, k_eff, n_eff,
//   acc_clear, acc_flush; perf_cycles when CONV1_SCHED_PERF_EN is defined.
module conv1_tile_scheduler
  import backbone_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int K_TILE  = DEF_K_TILE,
  parameter int K_TOTAL = DEF_K_TOTAL,
  parameter int N_TOTAL = DEF_N_TOTAL,
  parameter int IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ld_start,
  input  logic             ld_done,
  output logic             cmp_start,
  input  logic             cmp_done,
  output logic [IDX_W-1:0] tile_k_base,
  output logic [IDX_W-1:0] tile_n_base,
  output logic [IDX_W-1:0] k_eff,
  output logic [IDX_W-1:0] n_eff,
  output logic             acc_clear,
  output logic             acc_flush
`ifdef CONV1_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  sched_state_t state, state_nxt;

  logic [IDX_W-1:0] k_base, k_base_nxt;
  logic [IDX_W-1:0] n_base, n_base_nxt;

  int k_sum;
  int n_sum;

  assign k_sum = 32'(k_base) + K_TILE;
  assign n_sum = 32'(n_base) + COLS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      k_base <= '0;
      n_base <= '0;
    end else begin
      state  <= state_nxt;
      k_base <= k_base_nxt;
      n_base <= n_base_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    k_base_nxt = k_base;
    n_base_nxt = n_base;
    ld_start   = 1'b0;
    cmp_start  = 1'b0;
    acc_clear  = 1'b0;
    acc_flush  = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          k_base_nxt = '0;
          n_base_nxt = '0;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_start  = 1'b1;
        state_nxt = S_LWAIT;
      end
      S_LWAIT: begin
        if (ld_done) state_nxt = S_COMP;
      end
      S_COMP: begin
        cmp_start = 1'b1;
        acc_clear = (k_base == '0);
        // last K tile of this column group
        acc_flush = (k_sum >= K_TOTAL);
        state_nxt = S_CWAIT;
      end
      S_CWAIT: begin
        if (cmp_done) state_nxt = S_ADV;
      end
      S_ADV: begin
        if (k_sum < K_TOTAL) begin
          k_base_nxt = IDX_W'(k_sum);
          state_nxt  = S_LOAD;
        end else begin
          k_base_nxt = '0;
          if (n_sum < N_TOTAL) begin
            n_base_nxt = IDX_W'(n_sum);
            state_nxt  = S_LOAD;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_FIN: begin
        done       = 1'b1;
        k_base_nxt = '0;
        n_base_nxt = '0;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt  = S_IDLE;
        k_base_nxt = '0;
        n_base_nxt = '0;
      end
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign tile_k_base = k_base;
  assign tile_n_base = n_base;

  // Held at zero while idle so the block is fully quiet after reset.
  assign k_eff = busy
    ? IDX_W'(tile_eff(32'(k_base), K_TILE, K_TOTAL))
    : '0;
  assign n_eff = busy
    ? IDX_W'(tile_eff(32'(n_base), COLS, N_TOTAL))
    : '0;

`ifdef CONV1_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state == S_IDLE && start) begin
      perf_q <= '0;
    end else if (busy && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
